// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the write-back path.
//   REG_ADDR_W / XLEN / NUM_REGS : register file geometry
//   REG_ZERO                     : index of the hard-wired zero register
//   wb_req_t                     : one write-back request payload {addr, data}
package regfile_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Picks the first requester at or after
// ptr, wrapping NUM_REQ-1 -> 0. The pointer register lives in the parent.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   en        : grant enable; when low no grant is issued
//   gnt       : one-hot grant (or zero)
//   gnt_idx   : index of the granted requester (0 when none)
//   gnt_valid : a grant was issued
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  int unsigned      idx;
  logic [PTR_W-1:0] sel;

  // Walk the requesters starting at ptr; the first valid one wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    sel       = '0;
    if (en) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        idx = (32'(ptr) + off) % NUM_REQ;
        sel = PTR_W'(idx);
        if (!gnt_valid && req[sel]) begin
          gnt[sel]  = 1'b1;
          gnt_idx   = sel;
          gnt_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among NUM_REQ write-back
// sources with round-robin arbitration and a one-cycle registered output.
// Writes to register 0 are accepted but never issued.
// Optional feature macro: WB_BYPASS_EN (adds read-port bypass muxes).
//   clk, rst          : clock, asynchronous active-high reset
//   reqValid/reqReady : per-requester handshake (reqReady one-hot or zero)
//   reqAddr/reqData   : packed per-requester payloads, slice i at [i*W +: W]
//   stall             : blocks new grants; never blocks the output stage
//   regWrite, writeRegister, writeData : register file write port
//   busy              : output stage holds a valid (possibly x0) write
//   rdAddrK/rfDataK -> bypassDataK (WB_BYPASS_EN only, combinational)
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = XLEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        reqValid,
  output logic [NUM_REQ-1:0]        reqReady,
  input  logic [NUM_REQ*ADDR_W-1:0] reqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  input  logic                      stall,
  output logic                      regWrite,
  output logic [ADDR_W-1:0]         writeRegister,
  output logic [DATA_W-1:0]         writeData,
  output logic                      busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]         rdAddr1,
  input  logic [ADDR_W-1:0]         rdAddr2,
  input  logic [DATA_W-1:0]         rfData1,
  input  logic [DATA_W-1:0]         rfData2,
  output logic [DATA_W-1:0]         bypassData1,
  output logic [DATA_W-1:0]         bypassData2
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               xfer;

  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;

  logic               we_d, busy_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  data_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (reqValid),
    .ptr       (ptr_q),
    .en        (~stall),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Ready is withheld for the whole reset window; a grant implies valid,
  // so any granted requester completes a transfer at the next edge.
  assign reqReady = gnt & {NUM_REQ{~rst}};
  assign xfer     = gnt_valid & ~rst;

  // One-hot payload mux for the winning requester.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_addr = reqAddr[i*ADDR_W +: ADDR_W];
        win_data = reqData[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next pointer and output stage; idle cycles hold index/data.
  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    busy_d = 1'b0;
    addr_d = writeRegister;
    data_d = writeData;
    if (xfer) begin
      ptr_d  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
      busy_d = 1'b1;
      // x0 writes occupy the stage but never reach the register file.
      we_d   = (win_addr != ZERO_IDX);
      addr_d = win_addr;
      data_d = win_data;
    end
  end

  // Pointer and output stage registers; reset discards any captured write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q         <= '0;
      regWrite      <= 1'b0;
      busy          <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else begin
      ptr_q         <= ptr_d;
      regWrite      <= we_d;
      busy          <= busy_d;
      writeRegister <= addr_d;
      writeData     <= data_d;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the write being issued this cycle to the read ports.
  always_comb begin
    bypassData1 = rfData1;
    bypassData2 = rfData2;
    if (rdAddr1 == ZERO_IDX) begin
      bypassData1 = '0;
    end else if (regWrite && (writeRegister == rdAddr1)) begin
      bypassData1 = writeData;
    end
    if (rdAddr2 == ZERO_IDX) begin
      bypassData2 = '0;
    end else if (regWrite && (writeRegister == rdAddr2)) begin
      bypassData2 = writeData;
    end
  end
`endif

endmodule
